// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP register-file sequencer.
package fp_seq_pkg;

    localparam int FLAGS_W = 5;

    // Bit positions of the accrued exception flags, NV in the MSB
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        STORE = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        KIND_ARITH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } req_kind_t;

endpackage

// File: rtl/fp_flag_accum.sv
// Sticky accrued-exception register; a clear in the same cycle as a new set
// keeps only the new flags.
module fp_flag_accum
    import fp_seq_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               set_en,
    input  logic [FLAGS_W-1:0] set_flags,
    output logic [FLAGS_W-1:0] flags
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            flags <= '0;
        end else if (clear) begin
            flags <= set_en ? set_flags : '0;
        end else if (set_en) begin
            flags <= flags | set_flags;
        end
    end

endmodule

// File: rtl/fp_rf_sequencer.sv
// Sequences ARITH / LOAD / STORE requests between the request port, the FP
// register file and an external FPU with a bounded wait for completion.
module fp_rf_sequencer
    import fp_seq_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_frm,
    input  logic [31:0] req_load_data,
    output logic [4:0]  f_rs1,
    output logic [4:0]  f_rs2,
    input  logic [31:0] f_rs1_data,
    input  logic [31:0] f_rs2_data,
    output logic [4:0]  f_rd,
    output logic [31:0] f_w_data,
    output logic        f_LW,
    output logic        f_SW,
    output logic        f_ready,
    output logic [2:0]  f_frm_in,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [2:0]  fpu_frm,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic [4:0]  flags,
    input  logic        flags_clear,
    output logic        store_valid,
    output logic [31:0] store_data,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t         state;
    seq_state_t         state_nxt;
    req_kind_t          req_kind_e;
    req_kind_t          kind_q;
    logic [4:0]         op_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [4:0]         rd_q;
    logic [2:0]         frm_q;
    logic [31:0]        load_data_q;
    logic [31:0]        opa_q;
    logic [31:0]        opb_q;
    logic [31:0]        result_q;
    logic [FLAGS_W-1:0] fpu_flags_q;
    logic               start_q;
    logic               timeout_q;
    logic               rst_done_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               accept;
    logic               exec_timeout;
    logic               arith_wb;

    assign req_kind_e   = req_kind_t'(req_kind);
    // rst_done_q keeps the block from accepting on the cycle reset is released
    assign accept       = (state == IDLE) && rst_done_q && req_valid;
    // A done in the last allowed EXEC cycle wins over the timeout
    assign exec_timeout = (state == EXEC) && !fpu_done
                          && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign arith_wb     = (state == WB) && (kind_q == KIND_ARITH);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        f_rd        = '0;
        f_w_data    = '0;
        f_LW        = 1'b0;
        f_SW        = 1'b0;
        f_ready     = 1'b0;
        store_valid = 1'b0;
        store_data  = '0;
        unique case (state)
            IDLE: begin
                req_ready = rst_done_q;
                if (accept) begin
                    if (req_kind_e == KIND_LOAD) begin
                        state_nxt = WB;
                    end else if (req_kind_e == KIND_ARITH || req_kind_e == KIND_STORE) begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                state_nxt = (kind_q == KIND_STORE) ? STORE : EXEC;
            end
            EXEC: begin
                if (fpu_done) begin
                    state_nxt = WB;
                end else if (exec_timeout) begin
                    state_nxt = IDLE;
                end
            end
            WB: begin
                state_nxt = IDLE;
                f_rd      = rd_q;
                f_ready   = (kind_q == KIND_ARITH);
                f_LW      = (kind_q == KIND_LOAD);
                f_w_data  = (kind_q == KIND_LOAD) ? load_data_q : result_q;
            end
            STORE: begin
                state_nxt   = IDLE;
                f_SW        = 1'b1;
                store_valid = 1'b1;
                store_data  = opb_q;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            kind_q      <= KIND_ARITH;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            frm_q       <= '0;
            load_data_q <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            fpu_flags_q <= '0;
            start_q     <= 1'b0;
            timeout_q   <= 1'b0;
            rst_done_q  <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (accept) begin
                kind_q      <= req_kind_e;
                op_q        <= req_op;
                rs1_q       <= req_rs1;
                rs2_q       <= req_rs2;
                rd_q        <= req_rd;
                frm_q       <= req_frm;
                load_data_q <= req_load_data;
            end
            if (state == READ) begin
                opa_q <= f_rs1_data;
                opb_q <= f_rs2_data;
            end
            start_q   <= (state == READ) && (kind_q == KIND_ARITH);
            wait_cnt  <= (state == EXEC) ? wait_cnt + 1'b1 : '0;
            timeout_q <= exec_timeout;
            if ((state == EXEC) && fpu_done) begin
                result_q    <= fpu_result;
                fpu_flags_q <= fpu_flags;
            end
        end
    end

    assign f_rs1       = rs1_q;
    assign f_rs2       = rs2_q;
    assign f_frm_in    = frm_q;
    assign fpu_op      = op_q;
    assign fpu_frm     = frm_q;
    assign fpu_a       = opa_q;
    assign fpu_b       = opb_q;
    assign fpu_start   = start_q;
    assign timeout_err = timeout_q;

    fp_flag_accum u_flag_accum (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (flags_clear),
        .set_en    (arith_wb),
        .set_flags (fpu_flags_q),
        .flags     (flags)
    );

endmodule

// File: tb/tb_fp_rf_sequencer.sv
// Directed bench for fp_rf_sequencer: a per-cycle expectation schedule built
// from each transaction's timeline, checked every cycle, plus literal pins.
module tb_fp_rf_sequencer;

    localparam int T  = 8;
    localparam int NC = 512;
    localparam logic [1:0] W_NONE = 2'd0, W_LOAD = 2'd1, W_ARITH = 2'd2, W_STORE = 2'd3;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  req_op, req_rs1, req_rs2, req_rd;
    logic [2:0]  req_frm;
    logic [31:0] req_load_data;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic [31:0] f_rs1_data, f_rs2_data, f_w_data;
    logic        f_LW, f_SW, f_ready;
    logic [2:0]  f_frm_in;
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic [2:0]  fpu_frm;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic [4:0]  flags;
    logic        flags_clear;
    logic        store_valid;
    logic [31:0] store_data;
    logic        timeout_err;

    logic [31:0] regs [32];
    assign f_rs1_data = regs[f_rs1];
    assign f_rs2_data = regs[f_rs2];

    always #5 clk = ~clk;

    fp_rf_sequencer #(.TIMEOUT(T)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_frm(req_frm), .req_load_data(req_load_data),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rs1_data(f_rs1_data), .f_rs2_data(f_rs2_data),
        .f_rd(f_rd), .f_w_data(f_w_data), .f_LW(f_LW), .f_SW(f_SW), .f_ready(f_ready),
        .f_frm_in(f_frm_in), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_frm(fpu_frm),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .flags(flags), .flags_clear(flags_clear),
        .store_valid(store_valid), .store_data(store_data), .timeout_err(timeout_err)
    );

    // Expectation schedule, indexed by cycle number
    logic        e_busy [NC];
    logic        e_start[NC];
    logic        e_exec [NC];
    logic        e_tmo  [NC];
    logic [1:0]  e_wk   [NC];
    logic [4:0]  e_rd   [NC];
    logic [31:0] e_data [NC];
    logic [4:0]  e_fl   [NC];
    logic [4:0]  e_op   [NC];
    logic [2:0]  e_frm  [NC];
    logic [31:0] e_a    [NC];
    logic [31:0] e_b    [NC];
    logic [2:0]  pin_k  [NC];
    logic [31:0] pin_v  [NC];

    int          cyc = 0;
    logic        rst_edge = 1'b1;
    int          pend_cyc = -1;
    logic [2:0]  pend_frm = '0;
    logic [4:0]  model_flags = '0;
    logic [2:0]  model_frm = '0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !n_rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NC) begin
            if (rst_edge) begin
                model_flags = '0;
                model_frm   = '0;
                chk("rst_all_zero", {31'd0, |{req_ready, f_rs1, f_rs2, f_rd, f_w_data, f_LW,
                    f_SW, f_ready, f_frm_in, fpu_start, fpu_op, fpu_a, fpu_b, fpu_frm, flags,
                    store_valid, store_data, timeout_err}}, 32'd0);
            end
            if (cyc == pend_cyc) model_frm = pend_frm;
            chk("req_ready", req_ready, !rst_edge && !e_busy[cyc]);
            chk("fpu_start", fpu_start, e_start[cyc]);
            chk("f_ready", f_ready, e_wk[cyc] == W_ARITH);
            chk("f_LW", f_LW, e_wk[cyc] == W_LOAD);
            chk("f_SW", f_SW, e_wk[cyc] == W_STORE);
            chk("store_valid", store_valid, e_wk[cyc] == W_STORE);
            chk("timeout_err", timeout_err, e_tmo[cyc]);
            chk("flags", flags, model_flags);
            chk("f_frm_in", f_frm_in, model_frm);
            if (e_wk[cyc] == W_LOAD || e_wk[cyc] == W_ARITH) begin
                chk("f_rd", f_rd, e_rd[cyc]);
                chk("f_w_data", f_w_data, e_data[cyc]);
            end
            if (e_wk[cyc] == W_STORE) chk("store_data", store_data, e_data[cyc]);
            if (e_exec[cyc]) begin
                chk("fpu_op", fpu_op, e_op[cyc]);
                chk("fpu_frm", fpu_frm, e_frm[cyc]);
                chk("fpu_a", fpu_a, e_a[cyc]);
                chk("fpu_b", fpu_b, e_b[cyc]);
            end
            case (pin_k[cyc])
                3'd1: chk("pin_flags", flags, pin_v[cyc]);
                3'd2: chk("pin_w_data", f_w_data, pin_v[cyc]);
                3'd3: chk("pin_store_data", store_data, pin_v[cyc]);
                3'd4: chk("pin_timeout", timeout_err, pin_v[cyc]);
                default: ;
            endcase
            // Flags seen after the coming edge
            if (flags_clear) model_flags = (e_wk[cyc] == W_ARITH) ? e_fl[cyc] : '0;
            else if (e_wk[cyc] == W_ARITH) model_flags = model_flags | e_fl[cyc];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic [2:0] k, input int ofs, input logic [31:0] v);
        pin_k[cyc + ofs] = k;
        pin_v[cyc + ofs] = v;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] frm,
                         input logic [31:0] ld);
        req_valid = 1'b1; req_kind = kind; req_op = op; req_rs1 = rs1; req_rs2 = rs2;
        req_rd = rd; req_frm = frm; req_load_data = ld;
        pend_cyc = cyc + 1;
        pend_frm = frm;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] frm);
        e_busy[cyc + 1] = 1'b1;
        e_wk[cyc + 1]   = W_LOAD;
        e_rd[cyc + 1]   = rd;
        e_data[cyc + 1] = data;
        issue(2'd1, 5'd0, 5'd0, 5'd0, rd, frm, data);
        tick();
    endtask

    // d >= 0: fpu_done arrives d cycles after fpu_start; d < 0: never arrives
    task automatic do_arith(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [4:0] op, input logic [2:0] frm, input int d,
                            input logic [31:0] res, input logic [4:0] fl, input logic clr);
        int s;
        int last;
        s = cyc + 2;
        last = (d < 0) ? s + T - 1 : s + d;
        for (int k = cyc + 1; k <= last; k++) e_busy[k] = 1'b1;
        e_start[s] = 1'b1;
        for (int k = s; k <= last; k++) begin
            e_exec[k] = 1'b1; e_op[k] = op; e_frm[k] = frm;
            e_a[k] = regs[rs1]; e_b[k] = regs[rs2];
        end
        if (d < 0) begin
            e_tmo[s + T] = 1'b1;
        end else begin
            e_busy[last + 1] = 1'b1;
            e_wk[last + 1]   = W_ARITH;
            e_rd[last + 1]   = rd;
            e_data[last + 1] = res;
            e_fl[last + 1]   = fl;
        end
        issue(2'd0, op, rs1, rs2, rd, frm, 32'd0);
        tick();
        if (d < 0) begin
            for (int k = 0; k < T; k++) tick();
            tick();
        end else begin
            for (int k = 0; k < d; k++) tick();
            fpu_done = 1'b1; fpu_result = res; fpu_flags = fl;
            tick();
            fpu_done = 1'b0;
            flags_clear = clr;
            tick();
            flags_clear = 1'b0;
        end
    endtask

    task automatic do_store(input logic [4:0] rs2, input logic [2:0] frm);
        e_busy[cyc + 1] = 1'b1;
        e_busy[cyc + 2] = 1'b1;
        e_wk[cyc + 2]   = W_STORE;
        e_data[cyc + 2] = regs[rs2];
        issue(2'd2, 5'd0, 5'd0, rs2, 5'd0, frm, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        for (int k = 0; k < NC; k++) begin
            e_busy[k] = 0; e_start[k] = 0; e_exec[k] = 0; e_tmo[k] = 0; e_wk[k] = W_NONE;
            e_rd[k] = 0; e_data[k] = 0; e_fl[k] = 0; e_op[k] = 0; e_frm[k] = 0;
            e_a[k] = 0; e_b[k] = 0; pin_k[k] = 0; pin_v[k] = 0;
        end
        for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k * 32'h0101);
        regs[1] = 32'h3F80_0000;
        regs[2] = 32'h4000_0000;
        regs[7] = 32'h4049_0FDB;
        n_rst = 1'b0; req_valid = 1'b0; req_kind = '0; req_op = '0; req_rs1 = '0;
        req_rs2 = '0; req_rd = '0; req_frm = '0; req_load_data = '0;
        fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0; flags_clear = 1'b0;

        tick(); tick(); tick();
        n_rst = 1'b1;
        tick();

        pin(3'd2, 1, 32'h3F80_0000);
        do_load(5'd3, 32'h3F80_0000, 3'd1);
        do_load(5'd9, 32'hC000_0000, 3'd2);

        do_arith(5'd1, 5'd2, 5'd5, 5'h03, 3'd0, 4, 32'h4040_0000, 5'b00001, 1'b0);
        do_arith(5'd3, 5'd4, 5'd6, 5'h0A, 3'd2, 0, 32'h4110_0000, 5'b10000, 1'b0);
        pin(3'd1, 0, 32'h0000_0011);
        do_arith(5'd1, 5'd2, 5'd7, 5'h05, 3'd3, 2, 32'hBF80_0000, 5'b00100, 1'b1);
        pin(3'd1, 0, 32'h0000_0004);

        pin(3'd3, 2, 32'h4049_0FDB);
        do_store(5'd7, 3'd4);

        pin(3'd4, 10, 32'd1);
        do_arith(5'd5, 5'd6, 5'd8, 5'h07, 3'd1, -1, 32'd0, 5'b11111, 1'b0);
        tick();

        do_arith(5'd2, 5'd1, 5'd10, 5'h11, 3'd4, T - 1, 32'h1234_5678, 5'b01000, 1'b0);
        pin(3'd1, 0, 32'h0000_000C);

        issue(2'd3, 5'h1F, 5'd1, 5'd2, 5'd3, 3'd7, 32'hDEAD_BEEF);
        tick();

        flags_clear = 1'b1;
        tick();
        flags_clear = 1'b0;
        pin(3'd1, 0, 32'd0);

        fpu_done = 1'b1; fpu_result = 32'hFFFF_FFFF; fpu_flags = 5'b11111;
        tick();
        fpu_done = 1'b0;
        tick();

        // Abort in EXEC: busy through the second EXEC cycle, then reset
        e_busy[cyc + 1] = 1'b1; e_busy[cyc + 2] = 1'b1; e_busy[cyc + 3] = 1'b1;
        e_start[cyc + 2] = 1'b1;
        for (int k = cyc + 2; k <= cyc + 3; k++) begin
            e_exec[k] = 1'b1; e_op[k] = 5'h02; e_frm[k] = 3'd5;
            e_a[k] = regs[4]; e_b[k] = regs[5];
        end
        issue(2'd0, 5'h02, 5'd4, 5'd5, 5'd12, 3'd5, 32'd0);
        tick();
        tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        fpu_done = 1'b1; fpu_result = 32'h5555_5555; fpu_flags = 5'b00010;
        tick();
        fpu_done = 1'b0;
        tick();

        do_load(5'd31, 32'h0BAD_F00D, 3'd6);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_rf_sequencer.md
FP_RF_SEQUENCER -- requirements
Module: fp_rf_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for fpu_done.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1), the request handshake.
REQ-005 The block SHALL have port req_kind, input, 2, request type: 0 = ARITH, 1 = LOAD, 2 = STORE, 3 = reserved.
REQ-006 The block SHALL have port req_op, input, 5, FPU operation code, passed through unmodified.
REQ-007 The block SHALL have ports req_rs1, req_rs2 and req_rd, input, 5 each, register indices.
REQ-008 The block SHALL have ports req_frm (input, 3, rounding mode) and req_load_data (input, 32, load value).
REQ-009 The block SHALL have ports f_rs1 and f_rs2, output, 5 each, register-file read addresses.
REQ-010 The block SHALL have ports f_rs1_data and f_rs2_data, input, 32 each, combinational register-file read data.
REQ-011 The block SHALL have ports f_rd (output, 5) and f_w_data (output, 32), the write address and write data.
REQ-012 The block SHALL have ports f_LW, f_SW and f_ready, output, 1 each, the register-file write controls.
REQ-013 The block SHALL have port f_frm_in, output, 3, rounding mode presented to the register file.
REQ-014 The block SHALL have ports fpu_start (output, 1), fpu_op (output, 5), fpu_a and fpu_b (output, 32 each) and fpu_frm (output, 3).
REQ-015 The block SHALL have ports fpu_done (input, 1), fpu_result (input, 32) and fpu_flags (input, 5, order NV DZ OF UF NX).
REQ-016 The block SHALL have ports flags (output, 5, sticky accrued exceptions) and flags_clear (input, 1).
REQ-017 The block SHALL have ports store_valid (output, 1), store_data (output, 32) and timeout_err (output, 1).

Function
REQ-018 The FSM SHALL have states IDLE, READ, EXEC, WB and STORE; req_ready SHALL equal 1 only in IDLE.
REQ-019 In IDLE with req_valid=1, the block SHALL capture kind, op, rs1, rs2, rd, frm and load_data; req_kind=3 SHALL be accepted and dropped.
REQ-020 LOAD SHALL go IDLE->WB with f_LW=1 and f_w_data=captured load_data, giving a write one cycle after accept.
REQ-021 ARITH SHALL go IDLE->READ; in READ, f_rs1 and f_rs2 SHALL drive the captured indices and fpu_a and fpu_b SHALL register the read data.
REQ-022 On entry to EXEC, fpu_start SHALL pulse for exactly one cycle; fpu_op and fpu_frm SHALL hold stable throughout EXEC.
REQ-023 In EXEC with fpu_done=1, the block SHALL latch fpu_result and fpu_flags and go to WB; fpu_done outside EXEC SHALL be ignored.
REQ-024 WB SHALL last one cycle with f_ready=1 (ARITH) or f_LW=1 (LOAD), f_rd=captured rd, f_SW=0, then return to IDLE.
REQ-025 STORE SHALL go IDLE->READ->STORE; in STORE, f_SW=1, store_valid=1 and store_data=rs2 data for one cycle, with no register write.
REQ-026 f_ready, f_LW and store_valid SHALL be 0 in all states other than those listed in REQ-024 and REQ-025.
REQ-027 f_frm_in SHALL hold the last accepted req_frm.
REQ-028 A wait counter SHALL count EXEC cycles; if it reaches TIMEOUT without fpu_done, timeout_err SHALL pulse for one cycle, there SHALL be no writeback, and the FSM SHALL go to IDLE.
REQ-029 flags SHALL OR in the latched fpu_flags in each ARITH WB cycle; flags_clear SHALL zero flags.
REQ-030 When flags_clear and a WB occur in the same cycle, the new flags value SHALL equal the latched fpu_flags only.
REQ-031 fpu_done arriving in the same cycle the counter hits TIMEOUT SHALL win, giving a normal WB and no timeout_err.

Reset
REQ-032 While n_rst=0 at a clk edge, the FSM SHALL go to IDLE and all outputs, flags, the counter and captured fields SHALL be 0.
REQ-033 Reset during EXEC or WB SHALL abort the operation with no register write after release.
REQ-034 The first request SHALL be accepted no earlier than one cycle after n_rst returns to 1.

Structure
REQ-035 Package fp_seq_pkg SHALL hold the state enum, the req_kind encoding, the flag bit positions and the FLAGS_W=5 constant.
REQ-036 One sub-module, fp_flag_accum, SHALL implement the sticky flags with clear priority; all other logic SHALL be in fp_rf_sequencer.

Verification
REQ-037 LOAD with rd=3 and load_data=0x3F800000 -> exactly one cycle with f_LW=1, f_rd=3 and f_w_data=0x3F800000, one cycle after accept.
REQ-038 ARITH with rs1=1, rs2=2, rd=5 and fpu_done 4 cycles after start -> fpu_a/fpu_b equal regs 1/2, one fpu_start pulse, then one f_ready cycle with f_rd=5.
REQ-039 STORE with rs2=7 holding 0x40490FDB -> one store_valid cycle with store_data=0x40490FDB and f_SW=1, and f_ready=0 throughout.
REQ-040 fpu_done never asserted with TIMEOUT=8 -> timeout_err pulses 8 cycles after start, there is no write, and req_ready returns to 1.
REQ-041 Two ARITH ops with fpu_flags 00001 then 10000 -> flags=10001; flags_clear together with a third WB with flags 00100 -> flags=00100.
REQ-042 n_rst=0 asserted during EXEC -> all outputs 0 at the next edge, and a late fpu_done causes no write.
